// File: rtl/core_pkg.sv
// Shared definitions for the instruction loader and its UART receiver.
package core_pkg;

    // 100 MHz system clock divided down to 115200 baud.
    localparam int CLK_PER_BIT_DEFAULT = 868;

    // Loader progress through the length header and the word payload.
    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_WORD,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling timer and stop-bit check.
module uart_rx
    import core_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLK_PER_BIT - 1);

    logic          sync1, sync2, rx_prev, armed;
    logic [1:0]    fill;
    logic          active;
    logic [3:0]    bit_idx;
    logic [TW-1:0] timer;
    logic [7:0]    shreg;

    // Synchronize RXD and arm start detection only once a real high has been seen.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep sync1->sync2->rx_prev a true shift chain;
        // blocking ones would collapse the flops into wires within one edge.
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
            fill    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sync1   <= rxd;
            sync2   <= sync1;
            rx_prev <= sync2;
            fill    <= {fill[0], 1'b1};
            // sync2 holds a real line sample only once fill[1] is set.
            if (fill[1] && sync2)
                armed <= 1'b1;
        end
    end

    // Bit timer: start recheck at half a bit, then data and stop at full-bit spacing.
    always_ff @(posedge clk) begin
        byte_valid <= 1'b0;
        frame_err  <= 1'b0;
        if (rst) begin
            active    <= 1'b0;
            bit_idx   <= 4'd0;
            timer     <= '0;
            shreg     <= 8'h00;
            byte_data <= 8'h00;
        end else if (!active) begin
            if (armed && rx_prev && !sync2) begin
                active  <= 1'b1;
                timer   <= HALF_M1;
                bit_idx <= 4'd0;
            end
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end else begin
            timer <= FULL_M1;
            if (bit_idx == 4'd0) begin
                // A start bit gone high by mid-bit was a glitch: drop it silently.
                if (sync2)
                    active <= 1'b0;
                else
                    bit_idx <= 4'd1;
            end else if (bit_idx <= 4'd8) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end else begin
                active <= 1'b0;
                if (sync2) begin
                    byte_valid <= 1'b1;
                    byte_data  <= shreg;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed, big-endian instruction stream from UART into instruction memory.
module inst_loader
    import core_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
    parameter int DEPTH       = 44,
    parameter int ADDR_W      = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RXD,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]       IMEM_WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    loader_state_t     state, next_state;
    logic              rx_valid, rx_ferr;
    logic [7:0]        rx_data;
    logic [7:0]        len_hi;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] n_last, word_idx;
    logic [1:0]        byte_cnt;
    // Only three earlier bytes are ever needed: the fourth completes the word.
    logic [23:0]       asm_word;
    logic              word_last;

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk        (CLK),
        .rst        (RST),
        .rxd        (RXD),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr)
    );

    assign n_words   = {len_hi, rx_data};
    assign word_last = (word_idx == n_last);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_LEN_HI;
        else     state <= next_state;
    end

    // Next-state decode; DONE and ERR hold until reset.
    always_comb begin
        // NOTE: the default on the first line covers every path through the case,
        // so no branch can leave next_state unassigned and infer a latch.
        next_state = state;
        case (state)
            ST_LEN_HI: begin
                if (rx_ferr)       next_state = ST_ERR;
                else if (rx_valid) next_state = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (rx_ferr) next_state = ST_ERR;
                else if (rx_valid) begin
                    if (n_words == 16'd0)            next_state = ST_DONE;
                    else if (n_words > 16'(DEPTH))   next_state = ST_ERR;
                    else                             next_state = ST_WORD;
                end
            end
            ST_WORD: begin
                if (rx_ferr) next_state = ST_ERR;
                else if (rx_valid && byte_cnt == 2'd3 && word_last)
                    next_state = ST_DONE;
            end
            default: next_state = state;
        endcase
    end

    // Header capture, word assembly and the one-cycle memory write strobe.
    always_ff @(posedge CLK) begin
        IMEM_WE <= 1'b0;
        if (RST) begin
            IMEM_ADDR  <= '0;
            IMEM_WDATA <= 32'h0;
            len_hi     <= 8'h00;
            n_last     <= '0;
            word_idx   <= '0;
            byte_cnt   <= 2'd0;
            asm_word   <= 24'h0;
        end else if (rx_valid) begin
            case (state)
                ST_LEN_HI: len_hi <= rx_data;
                ST_LEN_LO: begin
                    n_last   <= ADDR_W'(n_words - 16'd1);
                    word_idx <= '0;
                    byte_cnt <= 2'd0;
                end
                ST_WORD: begin
                    asm_word <= {asm_word[15:0], rx_data};
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == 2'd3) begin
                        IMEM_WE    <= 1'b1;
                        IMEM_ADDR  <= word_idx;
                        IMEM_WDATA <= {asm_word, rx_data};
                        word_idx   <= word_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state == ST_LEN_LO) || (state == ST_WORD);
    assign DONE = (state == ST_DONE);
    assign ERR  = (state == ST_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: directed UART streams, expected writes queued.
module tb_inst_loader;

    localparam int CP     = 16;
    localparam int DEPTH  = 44;
    localparam int ADDR_W = 6;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              RXD = 1'b1;
    logic              IMEM_WE;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic [31:0]       IMEM_WDATA;
    logic              BUSY, DONE, ERR;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passed = 0;

    inst_loader #(.CLK_PER_BIT(CP), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RXD        (RXD),
        .IMEM_WE    (IMEM_WE),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_WDATA (IMEM_WDATA),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        wr_t e;
        if (IMEM_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected",
                         IMEM_ADDR, IMEM_WDATA);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(IMEM_ADDR), 32'(e.addr));
                check("wr_data", IMEM_WDATA, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        RXD = 1'b0;
        repeat (CP) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CP) @(negedge CLK);
        end
        RXD = stop_ok;
        repeat (CP) @(negedge CLK);
        RXD = 1'b1;
        repeat (CP) @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--)
            send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset(input logic line);
        @(negedge CLK);
        RST = 1'b1;
        RXD = line;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic settle();
        repeat (3 * CP) @(negedge CLK);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge CLK);
        check("rst_we",    32'(IMEM_WE), 32'd0);
        check("rst_addr",  32'(IMEM_ADDR), 32'd0);
        check("rst_wdata", IMEM_WDATA, 32'd0);
        check("rst_busy",  32'(BUSY), 32'd0);
        check("rst_done",  32'(DONE), 32'd0);
        check("rst_err",   32'(ERR), 32'd0);
        RST = 1'b0;
        settle();

        // Half-bit glitch on idle line is rejected.
        RXD = 1'b0;
        repeat (CP / 2) @(negedge CLK);
        RXD = 1'b1;
        settle();
        check("glitch_busy", 32'(BUSY), 32'd0);
        check("glitch_err",  32'(ERR), 32'd0);
        check("glitch_done", 32'(DONE), 32'd0);

        // Two-word program.
        exp_q.push_back('{addr: 6'd0, data: 32'h2001_0005});
        exp_q.push_back('{addr: 6'd1, data: 32'h0800_0000});
        send_byte(8'h00, 1'b1);
        check("busy_after_len_hi", 32'(BUSY), 32'd1);
        send_byte(8'h02, 1'b1);
        send_word(32'h2001_0005);
        send_word(32'h0800_0000);
        settle();
        check("n2_done",       32'(DONE), 32'd1);
        check("n2_err",        32'(ERR), 32'd0);
        check("n2_busy",       32'(BUSY), 32'd0);
        check("n2_addr_hold",  32'(IMEM_ADDR), 32'd1);
        check("n2_wdata_hold", IMEM_WDATA, 32'h0800_0000);
        check("n2_drained",    32'(exp_q.size()), 32'd0);

        // Empty program.
        do_reset(1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        check("n0_done", 32'(DONE), 32'd1);
        check("n0_err",  32'(ERR), 32'd0);

        // Oversize program, then trailing bytes ignored.
        do_reset(1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h2D, 1'b1);
        settle();
        check("n45_err",  32'(ERR), 32'd1);
        check("n45_done", 32'(DONE), 32'd0);
        send_word(32'h0102_0304);
        settle();
        check("n45_err_sticky", 32'(ERR), 32'd1);
        check("n45_busy",       32'(BUSY), 32'd0);

        // Framing error on the third byte of word 0.
        do_reset(1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        settle();
        check("ferr_err",  32'(ERR), 32'd1);
        check("ferr_done", 32'(DONE), 32'd0);
        send_byte(8'hDD, 1'b1);
        send_byte(8'hEE, 1'b1);
        settle();
        check("ferr_err_sticky", 32'(ERR), 32'd1);

        // Line held low through and after reset is not a start bit.
        do_reset(1'b0);
        repeat (12 * CP) @(negedge CLK);
        check("low_line_err",  32'(ERR), 32'd0);
        check("low_line_busy", 32'(BUSY), 32'd0);
        RXD = 1'b1;
        settle();

        // Reset part-way through word 1, then a fresh one-word stream.
        exp_q.push_back('{addr: 6'd0, data: 32'h1122_3344});
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'h1122_3344);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        do_reset(1'b1);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_addr", 32'(IMEM_ADDR), 32'd0);
        exp_q.push_back('{addr: 6'd0, data: 32'hDEAD_BEEF});
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'hDEAD_BEEF);
        settle();
        check("n1_done",  32'(DONE), 32'd1);
        check("n1_err",   32'(ERR), 32'd0);
        check("n1_wdata", IMEM_WDATA, 32'hDEAD_BEEF);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 868, meaning CLK cycles per UART bit (100 MHz / 115200 baud).
REQ-002 The block SHALL have parameter DEPTH, default 44, meaning instruction-memory words available.
REQ-003 The block SHALL have parameter ADDR_W, default 6, meaning instruction address width; DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have port CLK  input  1  system clock; all logic on posedge.
REQ-005 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port RXD  input  1  UART serial input, idle high, asynchronous to CLK.
REQ-007 The block SHALL have port IMEM_WE  output  1  one-cycle write strobe to instruction memory.
REQ-008 The block SHALL have port IMEM_ADDR  output  ADDR_W  word address of the write.
REQ-009 The block SHALL have port IMEM_WDATA  output  32  instruction word to write.
REQ-010 The block SHALL have port BUSY  output  1  high from first length byte received until DONE or ERR.
REQ-011 The block SHALL have port DONE  output  1  sticky; program fully loaded, core may leave INIT.
REQ-012 The block SHALL have port ERR  output  1  sticky; framing error or oversize program.

Function
REQ-013 RXD SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Start bit SHALL be detected only on a synchronized high-to-low transition while the receiver is idle.
REQ-015 The receiver SHALL sample at CLK_PER_BIT/2 into the start bit, then every CLK_PER_BIT: start recheck, 8 data bits LSB first, 1 stop bit.
REQ-016 Start bit low at mid-sample failing (glitch) SHALL return the receiver to idle with no byte and no error.
REQ-017 Stop bit sampled low SHALL raise a framing error pulse and discard the byte.
REQ-018 A good byte SHALL produce a one-cycle byte-valid pulse with the 8-bit value.
REQ-019 Stream format SHALL be: 16-bit word count N big-endian (2 bytes), then N words of 4 bytes each, big-endian.
REQ-020 Loader FSM states SHALL be LEN_HI, LEN_LO, WORD, DONE, ERR; reset state LEN_HI.
REQ-021 LEN_HI -> LEN_LO on byte-valid; LEN_LO -> WORD if 0 < N <= DEPTH, DONE if N == 0, ERR if N > DEPTH.
REQ-022 In WORD, each byte SHALL shift into a 32-bit assembly register (new byte into bits 7:0); a 2-bit byte counter tracks position.
REQ-023 The cycle after the 4th byte-valid, IMEM_WE SHALL be high for exactly one cycle with IMEM_ADDR = word index and IMEM_WDATA = assembled word.
REQ-024 Word index SHALL start at 0 and increment after each write; after write N-1 the FSM SHALL enter DONE in the same cycle as the strobe.
REQ-025 DONE and ERR SHALL be terminal until RST; bytes and framing errors received in DONE/ERR SHALL be ignored and SHALL NOT write memory.
REQ-026 Framing error in LEN_HI, LEN_LO or WORD SHALL enter ERR; no further IMEM_WE.
REQ-027 IMEM_ADDR/IMEM_WDATA SHALL hold their last value when IMEM_WE is low.
REQ-028 BUSY SHALL equal (state != LEN_HI, DONE, ERR) OR (state == LEN_HI and receiver mid-byte is not counted); BUSY low in DONE/ERR.

Reset
REQ-029 On RST: IMEM_WE=0, IMEM_ADDR=0, IMEM_WDATA=0, BUSY=0, DONE=0, ERR=0, FSM=LEN_HI, receiver idle, synchronizer flops=1.
REQ-030 RST mid-byte or mid-word SHALL discard the partial byte/word; no write occurs in the reset cycle.
REQ-031 After RST, a RXD held low SHALL NOT be taken as a start bit until it has been seen high.

Structure
REQ-032 Loader state enum and default CLK_PER_BIT SHALL live in shared package core_pkg.
REQ-033 UART receive (synchronizer, bit timer, framing check) SHALL be sub-module uart_rx; inst_loader instantiates it once.

Verification
REQ-034 N=2, words 0x20010005, 0x08000000 at CLK_PER_BIT=16 -> writes (0,0x20010005),(1,0x08000000), DONE=1, ERR=0.
REQ-035 N=0 -> DONE=1 after LEN_LO byte, no IMEM_WE.
REQ-036 N=45 with DEPTH=44 -> ERR=1 after LEN_LO byte, no IMEM_WE, later bytes ignored.
REQ-037 Stop bit forced low on 3rd byte of word 0 -> ERR=1, no IMEM_WE ever.
REQ-038 RST asserted after 2 bytes of word 1, then full N=1 stream 0xDEADBEEF -> single write (0,0xDEADBEEF), DONE=1.
REQ-039 Half-bit-wide low glitch on idle RXD -> no byte-valid, no ERR, state unchanged.
